// File: rtl/ss_wb_pkg.sv
// Shared types for the Wishbone responder model: FSM states, response kinds
// and the address-range test used to decide err.
package ss_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_GAP
  } wbs_state_e;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_ACK,
    RESP_RTY,
    RESP_ERR
  } wb_resp_e;

  // True when every byte-address bit above the word index is zero.
  function automatic logic adr_in_range(input logic [31:0] adr, input int unsigned aw);
    return (adr >> (aw + 3)) == 32'd0;
  endfunction

endpackage

// File: rtl/ss_ram64.sv
// 2^AW x 64 single-port RAM: synchronous write with four low-word byte
// enables plus one high-word enable, registered read.
module ss_ram64 #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be_lo,
  input  logic          we_hi,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem_q [2**AW];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_lo[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (we_hi) mem_q[addr][63:32] <= wdata[63:32];
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ss_wbs_mem.sv
// Wishbone responder with programmable wait states and periodic retry, backed
// by a 64-bit RAM; stands in for the host bridge on the SG engine port.
//
// state  | meaning
// S_IDLE | waiting for cyc & stb; latches the request
// S_WAIT | counting wait states down to zero
// S_RESP | exactly one of ack/rty/err is high
// S_GAP  | responses low, initiator re-registers address
module ss_wbs_mem
  import ss_wb_pkg::*;
#(
  parameter int AW        = 10,
  parameter int WAIT      = 1,
  parameter int RTY_EVERY = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  input  logic        wbs_cab,
  input  logic [3:0]  wbs_sel,
  input  logic [31:0] wbs_adr,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_dat64_i,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] wbs_dat64_o,
  output logic        wbs_ack,
  output logic        wbs_rty,
  output logic        wbs_err,
  output logic [15:0] mem_beats
);

  localparam logic [3:0] WAIT_LD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [3:0] RTY_CNT = 4'(RTY_EVERY);

  wbs_state_e  state_q, state_d;
  wb_resp_e    resp_q, resp_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [63:0] wdat_q, wdat_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0] mem_beats_q, mem_beats_d;

  logic        idle;
  logic [31:0] cur_adr;
  logic        cur_we;
  logic [3:0]  cur_sel;
  logic [63:0] cur_wdat;
  logic        go_resp;
  logic        full_word;
  logic        ram_we;
  logic [3:0]  ram_be_lo;
  logic        ram_we_hi;
  logic [63:0] ram_rdata;
  logic        unused_ok;

  // With WAIT=0 the response is decided on the sampling edge itself, so the
  // request fields come straight from the bus while idle.
  always_comb begin
    idle     = (state_q == S_IDLE);
    cur_adr  = idle ? wbs_adr : adr_q;
    cur_we   = idle ? wbs_we : we_q;
    cur_sel  = idle ? wbs_sel : sel_q;
    cur_wdat = idle ? {wbs_dat64_i, wbs_dat_i} : wdat_q;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    adr_d      = adr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    go_resp    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (wbs_cyc && wbs_stb) begin
          adr_d  = wbs_adr;
          we_d   = wbs_we;
          sel_d  = wbs_sel;
          wdat_d = {wbs_dat64_i, wbs_dat_i};
          if (WAIT > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_LD;
          end else begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!wbs_cyc) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    resp_d = RESP_NONE;
    if (go_resp) begin
      if (!adr_in_range(cur_adr, AW))                        resp_d = RESP_ERR;
      else if ((RTY_EVERY != 0) && (beat_cnt_q == RTY_CNT)) resp_d = RESP_RTY;
      else                                                   resp_d = RESP_ACK;
    end

    beat_cnt_d = beat_cnt_q;
    if (!wbs_cyc)                 beat_cnt_d = 4'd0;
    else if (resp_d == RESP_RTY)  beat_cnt_d = 4'd0;
    else if (resp_d == RESP_ACK)  beat_cnt_d = beat_cnt_q + 4'd1;

    mem_beats_d = mem_beats_q;
    if ((resp_d == RESP_ACK) && (mem_beats_q != 16'hFFFF)) mem_beats_d = mem_beats_q + 16'd1;
  end

  // Memory is written on the same edge that raises ack; reset blocks it.
  always_comb begin
    full_word = (cur_sel == 4'h0) || (cur_sel == 4'hF);
    ram_we    = (resp_d == RESP_ACK) && cur_we && !wb_rst_i;
    ram_be_lo = ram_we ? (full_word ? 4'hF : cur_sel) : 4'h0;
    ram_we_hi = ram_we && full_word;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      resp_q      <= RESP_NONE;
      wait_cnt_q  <= 4'd0;
      adr_q       <= 32'd0;
      we_q        <= 1'b0;
      sel_q       <= 4'd0;
      wdat_q      <= 64'd0;
      beat_cnt_q  <= 4'd0;
      mem_beats_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      wait_cnt_q  <= wait_cnt_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      wdat_q      <= wdat_d;
      beat_cnt_q  <= beat_cnt_d;
      mem_beats_q <= mem_beats_d;
    end
  end

  ss_ram64 #(.AW(AW)) u_ram (
    .clk   (wb_clk_i),
    .addr  (cur_adr[AW+2:3]),
    .be_lo (ram_be_lo),
    .we_hi (ram_we_hi),
    .wdata (cur_wdat),
    .rdata (ram_rdata)
  );

  assign wbs_ack   = (resp_q == RESP_ACK);
  assign wbs_rty   = (resp_q == RESP_RTY);
  assign wbs_err   = (resp_q == RESP_ERR);
  assign {wbs_dat64_o, wbs_dat_o} = wbs_ack ? ram_rdata : 64'd0;
  assign mem_beats = mem_beats_q;

  assign unused_ok = ^{wbs_cab, cur_adr[2:0]};

endmodule

// File: tb/tb_ss_wbs_mem.sv
// Self-checking bench for ss_wbs_mem: directed scenarios followed by random
// bursts, all compared against a word-level memory/response model.
module tb_ss_wbs_mem;

  localparam int AW        = 10;
  localparam int WAIT      = 1;
  localparam int RTY_EVERY = 2;

  localparam logic [2:0] R_ACK = 3'b001;
  localparam logic [2:0] R_RTY = 3'b010;
  localparam logic [2:0] R_ERR = 3'b100;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc, wbs_stb, wbs_we, wbs_cab;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat_i, wbs_dat64_i;
  logic [31:0] wbs_dat_o, wbs_dat64_o;
  logic        wbs_ack, wbs_rty, wbs_err;
  logic [15:0] mem_beats;

  always #5 wb_clk_i = ~wb_clk_i;

  ss_wbs_mem #(.AW(AW), .WAIT(WAIT), .RTY_EVERY(RTY_EVERY)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_cyc     (wbs_cyc),
    .wbs_stb     (wbs_stb),
    .wbs_we      (wbs_we),
    .wbs_cab     (wbs_cab),
    .wbs_sel     (wbs_sel),
    .wbs_adr     (wbs_adr),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_dat64_i (wbs_dat64_i),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_dat64_o (wbs_dat64_o),
    .wbs_ack     (wbs_ack),
    .wbs_rty     (wbs_rty),
    .wbs_err     (wbs_err),
    .mem_beats   (mem_beats)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl_mem [int];
  int          mdl_beats = 0;
  int          mdl_bcnt  = 0;
  bit          fsm_idle  = 1'b0;
  logic [2:0]  resp_log [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_resp(input logic [31:0] a);
    if ((a >> (AW + 3)) != 32'd0) return R_ERR;
    if ((RTY_EVERY != 0) && (mdl_bcnt == RTY_EVERY)) return R_RTY;
    return R_ACK;
  endfunction

  // One strobe: from idle the response lands WAIT+1 edges later; with the
  // strobe re-raised right after a response it takes WAIT+3 edges.
  task automatic beat(input bit wr, input logic [31:0] a, input logic [3:0] s,
                      input logic [63:0] d, output logic [2:0] r);
    int          lat, k;
    logic [2:0]  er;
    logic [63:0] cur, nw;
    lat = fsm_idle ? WAIT + 1 : WAIT + 3;
    er  = exp_resp(a);
    k   = int'(a[AW+2:3]);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = wr; wbs_adr = a; wbs_sel = s;
    {wbs_dat64_i, wbs_dat_i} = d;
    for (int n = 1; n <= lat; n++) begin
      @(posedge wb_clk_i); #1;
      if (n < lat) begin
        chk("quiet", {61'd0, wbs_err, wbs_rty, wbs_ack}, 64'd0);
        chk("dat_idle", {wbs_dat64_o, wbs_dat_o}, 64'd0);
      end
    end
    r = {wbs_err, wbs_rty, wbs_ack};
    chk("resp", {61'd0, r}, {61'd0, er});
    cur = mdl_mem.exists(k) ? mdl_mem[k] : 64'hx;
    if (er == R_ACK) begin
      if (!wr && !$isunknown(cur)) chk("rdata", {wbs_dat64_o, wbs_dat_o}, cur);
      if (wr) begin
        if (s == 4'h0 || s == 4'hF) nw = d;
        else begin
          nw = cur;
          for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
        end
        mdl_mem[k] = nw;
      end
      mdl_bcnt++;
      if (mdl_beats < 65535) mdl_beats++;
    end else begin
      chk("dat_noack", {wbs_dat64_o, wbs_dat_o}, 64'd0);
      if (er == R_RTY) mdl_bcnt = 0;
    end
    chk("mem_beats", {48'd0, mem_beats}, 64'(mdl_beats));
    wbs_stb  = 1'b0;
    fsm_idle = 1'b0;
  endtask

  // Reissues the same beat while the model predicts a retry.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [3:0] s, input logic [63:0] d);
    logic [2:0] r;
    bit         again;
    for (int t = 0; t < 4; t++) begin
      again = (exp_resp(a) == R_RTY);
      beat(wr, a, s, d, r);
      resp_log.push_back(r);
      if (!again) break;
    end
  endtask

  task automatic end_cycle();
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    mdl_bcnt = 0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    fsm_idle = 1'b1;
  endtask

  logic [2:0]  exp_burst [5];
  int          mb0, len;
  logic [31:0] ra;
  logic [3:0]  rs;

  initial begin
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_cab = 0; wbs_sel = 0;
    wbs_adr = 0; wbs_dat_i = 0; wbs_dat64_i = 0;
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk("rst_resp", {61'd0, wbs_err, wbs_rty, wbs_ack}, 64'd0);
    chk("rst_dat", {wbs_dat64_o, wbs_dat_o}, 64'd0);
    chk("rst_beats", {48'd0, mem_beats}, 64'd0);
    wb_rst_i = 1'b0;
    fsm_idle = 1'b1;

    xfer(1'b1, 32'h40, 4'hF, 64'h11223344_55667788);
    end_cycle();
    xfer(1'b0, 32'h40, 4'hF, 64'd0);
    chk("rd_0x40", {wbs_dat64_o, wbs_dat_o}, 64'h11223344_55667788);
    chk("beats_after_rw", {48'd0, mem_beats}, 64'd2);
    end_cycle();

    xfer(1'b1, 32'h0, 4'h0, 64'd0);
    end_cycle();
    xfer(1'b1, 32'h0, 4'h3, 64'hAAAAAAAA_BBBBBBBB);
    end_cycle();
    xfer(1'b0, 32'h0, 4'hF, 64'd0);
    chk("sel_lanes", {wbs_dat64_o, wbs_dat_o}, 64'h00000000_0000BBBB);
    end_cycle();

    resp_log.delete();
    xfer(1'b0, 32'h0000_2000, 4'hF, 64'd0);
    chk("err_resp", {61'd0, resp_log[0]}, {61'd0, R_ERR});
    chk("err_beats", {48'd0, mem_beats}, 64'd5);
    end_cycle();

    for (int i = 0; i < 4; i++) xfer(1'b1, 32'h100 + 32'(i * 8), 4'hF, {$urandom, $urandom});
    end_cycle();
    resp_log.delete();
    mb0 = mdl_beats;
    for (int i = 0; i < 4; i++) xfer(1'b0, 32'h100 + 32'(i * 8), 4'hF, 64'd0);
    end_cycle();
    exp_burst = '{R_ACK, R_ACK, R_RTY, R_ACK, R_ACK};
    chk("burst_len", 64'(resp_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < resp_log.size(); i++)
      chk("burst_seq", {61'd0, resp_log[i]}, {61'd0, exp_burst[i]});
    chk("burst_beats", {48'd0, mem_beats}, 64'(mb0 + 4));

    // Drop cyc while the write is waiting: nothing may respond or land.
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_adr = 32'h40; wbs_sel = 4'hF;
    {wbs_dat64_i, wbs_dat_i} = 64'hDEADBEEF_CAFEF00D;
    @(posedge wb_clk_i); #1;
    wbs_cyc = 0; wbs_stb = 0;
    mdl_bcnt = 0;
    repeat (4) begin
      @(posedge wb_clk_i); #1;
      chk("abort_quiet", {61'd0, wbs_err, wbs_rty, wbs_ack}, 64'd0);
    end
    fsm_idle = 1'b1;
    xfer(1'b0, 32'h40, 4'hF, 64'd0);
    chk("abort_kept", {wbs_dat64_o, wbs_dat_o}, 64'h11223344_55667788);
    end_cycle();

    // Reset in the middle of a write beat.
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_adr = 32'h40; wbs_sel = 4'hF;
    {wbs_dat64_i, wbs_dat_i} = 64'h0BAD0BAD_0BAD0BAD;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("rst_mid_resp", {61'd0, wbs_err, wbs_rty, wbs_ack}, 64'd0);
    chk("rst_mid_beats", {48'd0, mem_beats}, 64'd0);
    wb_rst_i = 1'b0;
    wbs_cyc = 0; wbs_stb = 0;
    mdl_beats = 0; mdl_bcnt = 0;
    fsm_idle = 1'b1;
    xfer(1'b0, 32'h40, 4'hF, 64'd0);
    chk("rst_mid_kept", {wbs_dat64_o, wbs_dat_o}, 64'h11223344_55667788);
    end_cycle();

    for (int i = 0; i < 16; i++) xfer(1'b1, 32'(i * 8), 4'hF, {$urandom, $urandom});
    end_cycle();
    for (int b = 0; b < 30; b++) begin
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        ra = 32'($urandom_range(0, 15) * 8) | 32'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(AW + 3, 31));
        case ($urandom_range(0, 3))
          0:       rs = 4'h0;
          1:       rs = 4'hF;
          default: rs = 4'($urandom_range(1, 14));
        endcase
        xfer(1'($urandom_range(0, 1)), ra, rs, {$urandom, $urandom});
      end
      end_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
